imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Writes 32-bit program words into the byte-wide instruction memory in big-endian order
//   (MSB at lowest address), matching the order the fetch path reassembles in {a,a+1,a+2,a+3}.
//   Sits between a host/test word stream and the writable instruction memory port.
//   Used to program the memory before the fetch stage runs.
// PARAMETERS
//   MEM_BYTES   372  size of instruction memory in bytes; a byte write must stay below this address
//   ADDR_WIDTH  28   width of the byte address, same as the fetch address
// PORTS
//   clk        in   1           rising-edge clock
//   rst        in   1           synchronous, active-high reset
//   start      in   1           1-cycle pulse; clears pointer/flags, honoured only in IDLE or DONE
//   in_valid   in   1           in_data/in_last valid
//   in_ready   out  1           loader can accept a word this cycle
//   in_data    in   32          program word, bits [31:24] are written first
//   in_last    in   1           marks final word of the program
//   mem_we     out  1           byte write strobe to instruction memory
//   mem_addr   out  ADDR_WIDTH  byte address of the current write
//   mem_wdata  out  8           byte being written
//   busy       out  1           high while in the WRITE state
//   done       out  1           program load finished (sticky until start or rst)
//   overflow   out  1           a word would have exceeded MEM_BYTES (sticky until start or rst)
//   words      out  ADDR_WIDTH  count of words fully written since the last start/rst
// BEHAVIOUR
//   - All outputs are registered. On rst: state=IDLE, ptr=0, beat=0.
//     mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, overflow=0, words=0.
//   - The state is in_ready=(state==IDLE) and is combinational from the state register only.
//   - FSM states: IDLE, WRITE, DONE.
//   - IDLE:
//     - start=1 sets ptr=0, words=0, overflow=0. It takes priority; no word is accepted that cycle.
//     - Handshake is in_valid&&in_ready. On it, word and last are captured.
//     - If ptr+3 < MEM_BYTES: go to WRITE with beat=0.
//     - Else: drop the word, set overflow=1 and go to DONE (done=1).
//   - WRITE (exactly 4 cycles per word):
//     - beat b=0..3 drives mem_we=1, mem_addr=ptr, mem_wdata=word[31-8b -: 8], then ptr+=1.
//     - First byte strobe is the cycle after the accepting edge (latency 1).
//     - After beat 3: words+=1. If last go to DONE, else go to IDLE.
//     - Throughput: 1 word per 5 cycles.
//   - DONE: done=1, mem_we=0, in_ready=0. start returns to IDLE with ptr=0, done=0, overflow=0, words=0.
//   - start during WRITE is ignored. in_valid outside IDLE is ignored; the word must be held by the source.
//   - mem_we=0 in every cycle outside WRITE; mem_addr/mem_wdata hold their last value.
//   - Arithmetic: ptr is ADDR_WIDTH bits, unsigned. Bounds check uses ptr+3 at full width, no wrap.
//     A word that ends exactly at MEM_BYTES-1 is legal.
//   - rst mid-WRITE aborts immediately. The partial word is not counted.
//     No further strobes follow; outputs return to reset values the next cycle.
// TESTING
//   1. rst, then accept 0x20080000 (last=1)
//      -> mem_we 4 cycles, addr 0..3, data 20,08,00,00; done=1, words=1.
//   2. Stream 0x20090001, 0xAD490000, 0x01284020 (last on 3rd)
//      -> bytes at 0..11 in big-endian order; in_ready low 4 cycles/word; words=3.
//   3. MEM_BYTES=8, send 3 words
//      -> words at 0..7 written; 3rd dropped with no strobe; overflow=1, done=1, words=2.
//   4. Assert rst at beat 2 of a word
//      -> next cycle mem_we=0 and all outputs are reset values; next word is written at addr 0.
//   5. Pulse start while busy, then again in DONE
//      -> first is ignored; second clears done/overflow/words and ptr=0.
//   6. Load a program, then read it back through the fetch path at addr 0,4
//      -> d_out equals the original words.

Source files
------------

// File: rtl/imem_loader_if.sv
// Word-stream input and byte-wide instruction-memory write port of the loader.
// The slave side is the loader; the master side is the host stream plus memory.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 28
);
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_data;
  logic                  in_last;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Splits 32-bit program words into four big-endian byte writes (MSB at the lowest
// address) so the fetch path can reassemble them as {a,a+1,a+2,a+3}.
module imem_loader #(
  parameter int MEM_BYTES  = 372,
  parameter int ADDR_WIDTH = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  imem_loader_if.slave          bus,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] words
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [1:0]            beat;
  logic [31:0]           word;
  logic                  last;
  logic                  accept;
  logic                  fits;
  logic [ADDR_WIDTH:0]   end_addr;

  // One extra bit so ptr+3 never wraps before the bound check.
  assign end_addr    = {1'b0, ptr} + (ADDR_WIDTH+1)'(3);
  assign fits        = end_addr < (ADDR_WIDTH+1)'(MEM_BYTES);
  assign accept      = (state == IDLE) && !start && bus.in_valid;
  assign bus.in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fits ? WRITE : DONE;
      WRITE:   if (beat == 2'd3) state_nxt = last ? DONE : IDLE;
      DONE:    if (start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      beat          <= '0;
      word          <= '0;
      last          <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      words         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ptr      <= '0;
            words    <= '0;
            overflow <= 1'b0;
          end else if (bus.in_valid) begin
            if (fits) begin
              // Beat 0 goes out on the accepting edge; the rest shift out of word.
              word          <= {bus.in_data[23:0], 8'h00};
              last          <= bus.in_last;
              beat          <= '0;
              busy          <= 1'b1;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= ptr;
              bus.mem_wdata <= bus.in_data[31:24];
            end else begin
              overflow <= 1'b1;
              done     <= 1'b1;
            end
          end
        end
        WRITE: begin
          ptr <= ptr + ADDR_WIDTH'(1);
          if (beat == 2'd3) begin
            bus.mem_we <= 1'b0;
            busy       <= 1'b0;
            words      <= words + ADDR_WIDTH'(1);
            if (last) done <= 1'b1;
          end else begin
            beat          <= beat + 2'd1;
            bus.mem_addr  <= ptr + ADDR_WIDTH'(1);
            bus.mem_wdata <= word[31:24];
            word          <= {word[23:0], 8'h00};
          end
        end
        DONE: begin
          if (start) begin
            ptr      <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            words    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a full-size loader plus an 8-byte one for the
// overflow boundary, with a byte-memory model standing in for the fetch path.
module tb_imem_loader;

  localparam int AW = 28;

  logic          clk = 1'b0;
  logic          rst, start, valid, last, sel;
  logic [31:0]   data;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_WIDTH(AW)) bb ();
  imem_loader_if #(.ADDR_WIDTH(AW)) bs ();

  assign bb.in_valid = valid & ~sel;
  assign bb.in_data  = data;
  assign bb.in_last  = last;
  assign bs.in_valid = valid & sel;
  assign bs.in_data  = data;
  assign bs.in_last  = last;

  logic          busy_b, done_b, ovf_b, busy_s, done_s, ovf_s;
  logic [AW-1:0] words_b, words_s;

  imem_loader #(.MEM_BYTES(372), .ADDR_WIDTH(AW)) u_big (
    .clk(clk), .rst(rst), .start(start & ~sel), .bus(bb.slave),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .words(words_b)
  );

  imem_loader #(.MEM_BYTES(8), .ADDR_WIDTH(AW)) u_small (
    .clk(clk), .rst(rst), .start(start & sel), .bus(bs.slave),
    .busy(busy_s), .done(done_s), .overflow(ovf_s), .words(words_s)
  );

  // Outputs of whichever loader sel points at
  logic          rdy_m, we_m, busy_m, done_m, ovf_m;
  logic [AW-1:0] addr_m, words_m;
  logic [7:0]    wdata_m;
  always_comb begin
    if (sel) begin
      rdy_m = bs.in_ready; we_m = bs.mem_we; addr_m = bs.mem_addr; wdata_m = bs.mem_wdata;
      busy_m = busy_s; done_m = done_s; ovf_m = ovf_s; words_m = words_s;
    end else begin
      rdy_m = bb.in_ready; we_m = bb.mem_we; addr_m = bb.mem_addr; wdata_m = bb.mem_wdata;
      busy_m = busy_b; done_m = done_b; ovf_m = ovf_b; words_m = words_b;
    end
  end

  logic [7:0] mem [0:371];
  always @(posedge clk) if (bb.mem_we && bb.mem_addr < 372) mem[bb.mem_addr] <= bb.mem_wdata;

  function automatic logic [31:0] fetch(input int a);
    return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".we"},    32'(we_m),    0);
    chk({nm, ".addr"},  32'(addr_m),  0);
    chk({nm, ".wdata"}, 32'(wdata_m), 0);
    chk({nm, ".busy"},  32'(busy_m),  0);
    chk({nm, ".done"},  32'(done_m),  0);
    chk({nm, ".ovf"},   32'(ovf_m),   0);
    chk({nm, ".words"}, 32'(words_m), 0);
    chk({nm, ".rdy"},   32'(rdy_m),   1);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Offers one word, then checks the four byte strobes; returns at the beat-3 negedge.
  task automatic put_word(input logic [31:0] d, input logic l, input int base, input string nm);
    int n = 0;
    data = d; last = l; valid = 1'b1;
    while (!rdy_m && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      chk({nm, ".ready_timeout"}, 0, 1);
      valid = 1'b0;
      return;
    end
    @(posedge clk); #1 valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk($sformatf("%s.we%0d", nm, b),    32'(we_m),    1);
      chk($sformatf("%s.addr%0d", nm, b),  32'(addr_m),  32'(base + b));
      chk($sformatf("%s.data%0d", nm, b),  32'(wdata_m), 32'(d[31-8*b -: 8]));
      chk($sformatf("%s.rdy%0d", nm, b),   32'(rdy_m),   0);
      chk($sformatf("%s.busy%0d", nm, b),  32'(busy_m),  1);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          base;
    int          exp_words;
    logic        exp_done;
  } vec_t;

  vec_t tbl [3];

  initial begin
    tbl[0] = '{32'h20090001, 1'b0, 0, 1, 1'b0};
    tbl[1] = '{32'hAD490000, 1'b0, 4, 2, 1'b0};
    tbl[2] = '{32'h01284020, 1'b1, 8, 3, 1'b1};

    sel = 1'b0; rst = 1'b1; start = 1'b0; valid = 1'b0; data = '0; last = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("rst_big");
    sel = 1'b1; #1;
    chk_reset("rst_small");
    sel = 1'b0; #1;

    // Single word with last
    put_word(32'h20080000, 1'b1, 0, "t1");
    @(negedge clk);
    chk("t1.we_off", 32'(we_m),    0);
    chk("t1.done",   32'(done_m),  1);
    chk("t1.words",  32'(words_m), 1);
    chk("t1.rdy",    32'(rdy_m),   0);
    chk("t1.busy",   32'(busy_m),  0);

    pulse_start();
    @(negedge clk);
    chk("t1.clr_done",  32'(done_m),  0);
    chk("t1.clr_words", 32'(words_m), 0);

    // Back-to-back stream, one word every 5 cycles
    foreach (tbl[i]) begin
      put_word(tbl[i].data, tbl[i].last, tbl[i].base, $sformatf("t2[%0d]", i));
      @(negedge clk);
      chk($sformatf("t2[%0d].words", i), 32'(words_m), 32'(tbl[i].exp_words));
      chk($sformatf("t2[%0d].done", i),  32'(done_m),  32'(tbl[i].exp_done));
      chk($sformatf("t2[%0d].rdy", i),   32'(rdy_m),   32'(!tbl[i].exp_done));
      chk($sformatf("t2[%0d].we", i),    32'(we_m),    0);
    end

    // Fetch-path readback
    chk("t6.fetch0", fetch(0), 32'h20090001);
    chk("t6.fetch4", fetch(4), 32'hAD490000);
    chk("t6.fetch8", fetch(8), 32'h01284020);

    // start during WRITE is ignored
    pulse_start();
    data = 32'h12345678; last = 1'b1; valid = 1'b1;
    @(negedge clk);
    chk("t5.rdy", 32'(rdy_m), 1);
    @(posedge clk); #1 valid = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("t5.b2.we",   32'(we_m),    1);
    chk("t5.b2.addr", 32'(addr_m),  2);
    chk("t5.b2.data", 32'(wdata_m), 32'h56);
    @(negedge clk);
    chk("t5.b3.addr", 32'(addr_m),  3);
    chk("t5.b3.data", 32'(wdata_m), 32'h78);
    @(negedge clk);
    chk("t5.done",  32'(done_m),  1);
    chk("t5.words", 32'(words_m), 1);
    // in_valid while DONE must not be taken
    data = 32'hDEADBEEF; last = 1'b0; valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t5.done_we",    32'(we_m),    0);
      chk("t5.done_words", 32'(words_m), 1);
    end
    valid = 1'b0;
    pulse_start();
    @(negedge clk);
    chk("t5.clr_done",  32'(done_m),  0);
    chk("t5.clr_words", 32'(words_m), 0);
    chk("t5.clr_rdy",   32'(rdy_m),   1);
    put_word(32'hA5A5F00F, 1'b1, 0, "t5.ptr0");

    // Overflow on an 8-byte memory
    sel = 1'b1; #1;
    put_word(32'h11223344, 1'b0, 0, "t3.w0");
    put_word(32'h55667788, 1'b0, 4, "t3.w1");
    @(negedge clk);
    chk("t3.words2", 32'(words_m), 2);
    data = 32'h99AABBCC; last = 1'b1; valid = 1'b1;
    chk("t3.rdy", 32'(rdy_m), 1);
    @(posedge clk); #1 valid = 1'b0;
    @(negedge clk);
    chk("t3.we",    32'(we_m),    0);
    chk("t3.ovf",   32'(ovf_m),   1);
    chk("t3.done",  32'(done_m),  1);
    chk("t3.words", 32'(words_m), 2);
    chk("t3.addr",  32'(addr_m),  7);
    chk("t3.wdata", 32'(wdata_m), 32'h88);
    pulse_start();
    @(negedge clk);
    chk("t3.clr_ovf",  32'(ovf_m),  0);
    chk("t3.clr_done", 32'(done_m), 0);
    sel = 1'b0; #1;

    // Reset in the middle of a word
    pulse_start();
    put_word(32'h01020304, 1'b0, 0, "t4.pre");
    data = 32'hCAFEBABE; last = 1'b0; valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("t4.b2.addr", 32'(addr_m),  6);
    chk("t4.b2.data", 32'(wdata_m), 32'hBA);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("t4.after");
    put_word(32'h0BADF00D, 1'b1, 0, "t4.next");
    @(negedge clk);
    chk("t4.words", 32'(words_m), 1);
    chk("t4.done",  32'(done_m),  1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
